busy_bit_table: RTL and testbench

//   Index-to-one-hot decoding scoreboard: the write-side counterpart of the

---
 rtl/busy_bit_table.sv | 118 +++++++++++
 tb/tb_busy_bit_table.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/busy_bit_table.sv
// Busy-bit scoreboard: decodes one set port and two clear ports into one-hot masks
// and keeps a registered busy vector, live count, full/empty flags and a sticky error.
module busy_bit_table #(
    parameter int WIDTH = 64,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_valid,
    input  logic [IDXW-1:0]  set_idx,
    output logic             set_ready,
    input  logic             clr0_valid,
    input  logic [IDXW-1:0]  clr0_idx,
    input  logic             clr1_valid,
    input  logic [IDXW-1:0]  clr1_idx,
    input  logic             flush,
    output logic [WIDTH-1:0] busy,
    output logic [IDXW:0]    busy_count,
    output logic             all_busy,
    output logic             none_busy,
    output logic             err
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] busy_q, busy_d;
    logic [IDXW:0]    busy_count_q, busy_count_d;
    logic             all_busy_q, all_busy_d;
    logic             none_busy_q, none_busy_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] set_dec, c0_dec, c1_dec;
    logic [WIDTH-1:0] set_m, c0_m, c1_m, clr_m;
    logic             take, set_act, c0_act, c1_act;
    logic             set_eff, c0_eff, c1_eff, err_hit;
    logic [IDXW:0]    inc, dec;

    // Out-of-range indices match no bit, so their masks come out all-zero.
    always_comb begin
        set_dec = '0;
        c0_dec  = '0;
        c1_dec  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_dec[i] = (set_idx  == IDXW'(i));
            c0_dec[i]  = (clr0_idx == IDXW'(i));
            c1_dec[i]  = (clr1_idx == IDXW'(i));
        end
    end

    assign set_ready = (state_q == ST_RUN);
    assign take      = set_ready & ~flush;
    assign set_act   = take & set_valid;
    assign c0_act    = take & clr0_valid;
    assign c1_act    = take & clr1_valid;

    assign set_m = {WIDTH{set_act}} & set_dec;
    assign c0_m  = {WIDTH{c0_act}} & c0_dec;
    assign c1_m  = {WIDTH{c1_act}} & c1_dec;
    assign clr_m = c0_m | c1_m;

    // A set overrides a clear of the same entry; duplicate clears count once.
    assign set_eff = |(set_m & ~busy_q);
    assign c0_eff  = |(c0_m & busy_q & ~set_m);
    assign c1_eff  = |(c1_m & busy_q & ~set_m & ~c0_m);
    assign inc     = {{IDXW{1'b0}}, set_eff};
    assign dec     = {{IDXW{1'b0}}, c0_eff} + {{IDXW{1'b0}}, c1_eff};

    assign err_hit = (set_act & (~(|set_dec) | (|(set_m & busy_q & ~clr_m))))
                   | (c0_act & ~(|(c0_m & busy_q)))
                   | (c1_act & ~(|(c1_m & busy_q)))
                   | (c0_act & c1_act & (clr0_idx == clr1_idx));

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        busy_count_d = busy_count_q;
        err_d        = err_q;
        if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
        end else if (flush) begin
            state_d      = ST_FLUSH;
            busy_d       = '0;
            busy_count_d = '0;
        end else begin
            busy_d       = (busy_q & ~clr_m) | set_m;
            busy_count_d = busy_count_q + inc - dec;
            err_d        = err_q | err_hit;
        end
        all_busy_d  = (busy_count_d == (IDXW+1)'(WIDTH));
        none_busy_d = (busy_count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            busy_q       <= '0;
            busy_count_q <= '0;
            all_busy_q   <= 1'b0;
            none_busy_q  <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            all_busy_q   <= all_busy_d;
            none_busy_q  <= none_busy_d;
            err_q        <= err_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = busy_count_q;
    assign all_busy   = all_busy_q;
    assign none_busy  = none_busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_busy_bit_table.sv
// Scoreboard bench for busy_bit_table: a 64-entry and a 48-entry instance share
// stimulus; an array-level reference model predicts every cycle.
module tb_busy_bit_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, set_valid, clr0_valid, clr1_valid, flush;
    logic [5:0] set_idx, clr0_idx, clr1_idx;

    logic        a_ready, a_all, a_none, a_err;
    logic [63:0] a_busy;
    logic [6:0]  a_count;
    logic        b_ready, b_all, b_none, b_err;
    logic [47:0] b_busy;
    logic [6:0]  b_count;

    busy_bit_table #(.WIDTH(64)) u_a (
        .clk(clk), .rst(rst), .set_valid(set_valid), .set_idx(set_idx), .set_ready(a_ready),
        .clr0_valid(clr0_valid), .clr0_idx(clr0_idx), .clr1_valid(clr1_valid), .clr1_idx(clr1_idx),
        .flush(flush), .busy(a_busy), .busy_count(a_count), .all_busy(a_all),
        .none_busy(a_none), .err(a_err)
    );

    busy_bit_table #(.WIDTH(48)) u_b (
        .clk(clk), .rst(rst), .set_valid(set_valid), .set_idx(set_idx), .set_ready(b_ready),
        .clr0_valid(clr0_valid), .clr0_idx(clr0_idx), .clr1_valid(clr1_valid), .clr1_idx(clr1_idx),
        .flush(flush), .busy(b_busy), .busy_count(b_count), .all_busy(b_all),
        .none_busy(b_none), .err(b_err)
    );

    typedef struct {
        logic [63:0] busy;
        int          count;
        bit          err;
        bit          flushing;
    } mstate_t;

    typedef struct {
        logic [63:0] busy;
        int          count;
        bit          all_b;
        bit          none_b;
        bit          err;
        bit          ready;
    } exp_t;

    mstate_t ma, mb;
    exp_t    qa[$];
    exp_t    qb[$];
    int      total = 0;
    int      bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mstate_t step(input mstate_t s, input int w, input bit r,
                                     input bit sv, input int si, input bit c0v, input int c0i,
                                     input bit c1v, input int c1i, input bit fl);
        mstate_t n;
        bit s_in, c0_in, c1_in;
        n = s;
        if (r) begin
            n.busy = '0; n.count = 0; n.err = 0; n.flushing = 0;
            return n;
        end
        if (s.flushing) begin
            n.flushing = 0;
            return n;
        end
        if (fl) begin
            n.busy = '0; n.count = 0; n.flushing = 1;
            return n;
        end
        s_in  = sv  && (si  < w);
        c0_in = c0v && (c0i < w);
        c1_in = c1v && (c1i < w);
        if ((sv && !s_in) || (c0v && !c0_in) || (c1v && !c1_in)) n.err = 1;
        if (c0v && c1v && c0i == c1i) n.err = 1;
        if (c0_in && !s.busy[c0i]) n.err = 1;
        if (c1_in && !s.busy[c1i]) n.err = 1;
        if (s_in && s.busy[si] && !((c0_in && c0i == si) || (c1_in && c1i == si))) n.err = 1;
        if (c0_in) n.busy[c0i] = 1'b0;
        if (c1_in) n.busy[c1i] = 1'b0;
        if (s_in)  n.busy[si]  = 1'b1;
        n.count = 0;
        for (int i = 0; i < w; i++) n.count += int'(n.busy[i]);
        return n;
    endfunction

    function automatic exp_t mk(input mstate_t s, input int w);
        exp_t e;
        e.busy   = s.busy;
        e.count  = s.count;
        e.all_b  = (s.count == w);
        e.none_b = (s.count == 0);
        e.err    = s.err;
        e.ready  = !s.flushing;
        return e;
    endfunction

    task automatic cyc(input bit r, input bit sv, input int si, input bit c0v, input int c0i,
                       input bit c1v, input int c1i, input bit fl);
        @(negedge clk);
        rst = r; set_valid = sv; set_idx = 6'(si);
        clr0_valid = c0v; clr0_idx = 6'(c0i);
        clr1_valid = c1v; clr1_idx = 6'(c1i);
        flush = fl;
        ma = step(ma, 64, r, sv, si, c0v, c0i, c1v, c1i, fl);
        mb = step(mb, 48, r, sv, si, c0v, c0i, c1v, c1i, fl);
        qa.push_back(mk(ma, 64));
        qb.push_back(mk(mb, 48));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUTs present registered outputs; compare against queue heads.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_busy",  a_busy,  e.busy);
                chk("a_count", 64'(a_count), 64'(e.count));
                chk("a_all",   64'(a_all),   64'(e.all_b));
                chk("a_none",  64'(a_none),  64'(e.none_b));
                chk("a_err",   64'(a_err),   64'(e.err));
                chk("a_ready", 64'(a_ready), 64'(e.ready));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_busy",  {16'h0, b_busy}, e.busy);
                chk("b_count", 64'(b_count), 64'(e.count));
                chk("b_all",   64'(b_all),   64'(e.all_b));
                chk("b_none",  64'(b_none),  64'(e.none_b));
                chk("b_err",   64'(b_err),   64'(e.err));
                chk("b_ready", 64'(b_ready), 64'(e.ready));
            end
        end
    end

    initial begin
        bit sv, c0v, c1v, fl, r;
        rst = 1; set_valid = 0; set_idx = 0; clr0_valid = 0; clr0_idx = 0;
        clr1_valid = 0; clr1_idx = 0; flush = 0;
        ma = '{busy: '0, count: 0, err: 0, flushing: 0};
        mb = ma;

        do_reset();
        idle();
        chk("rst_busy",  a_busy, 64'h0);
        chk("rst_none",  64'(a_none), 64'h1);
        chk("rst_all",   64'(a_all), 64'h0);
        chk("rst_err",   64'(a_err), 64'h0);
        chk("rst_ready", 64'(a_ready), 64'h1);

        // Consecutive sets
        cyc(0, 1, 5, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 63, 0, 0, 0, 0, 0);
        idle();
        chk("t1_busy",  a_busy, 64'h8000_0000_0000_0021);
        chk("t1_count", 64'(a_count), 64'd3);
        chk("t1_err",   64'(a_err), 64'h0);

        // Set beats clear of the same index; dual clear of one index
        cyc(0, 1, 7, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 1, 7, 1, 7, 0, 0, 0);
        idle();
        chk("t2_bit7",  64'(a_busy[7]), 64'h1);
        chk("t2_count", 64'(a_count), 64'd4);
        chk("t2_err",   64'(a_err), 64'h0);
        cyc(0, 0, 0, 1, 7, 1, 7, 0);
        idle();
        chk("t2_bit7_clr", 64'(a_busy[7]), 64'h0);
        chk("t2_count2",   64'(a_count), 64'd3);
        chk("t2_err2",     64'(a_err), 64'h1);

        // Full table
        do_reset();
        for (int i = 0; i < 64; i++) cyc(0, 1, i, 0, 0, 0, 0, 0);
        idle();
        chk("t3_all",   64'(a_all), 64'h1);
        chk("t3_count", 64'(a_count), 64'd64);
        cyc(0, 0, 0, 0, 0, 1, 10, 0);
        idle();
        chk("t3_all_clr",   64'(a_all), 64'h0);
        chk("t3_count_clr", 64'(a_count), 64'd63);
        cyc(0, 1, 10, 0, 0, 0, 0, 0);
        idle();
        chk("t3_all_again", 64'(a_all), 64'h1);

        // Flush wins, then one blocked cycle
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, i, 0, 0, 0, 0, 0);
        idle();
        chk("t4_busy_pre", a_busy, 64'h0F);
        cyc(0, 1, 20, 1, 1, 0, 0, 1);
        cyc(0, 1, 20, 0, 0, 0, 0, 0);
        chk("t4_busy",  a_busy, 64'h0);
        chk("t4_count", 64'(a_count), 64'd0);
        chk("t4_none",  64'(a_none), 64'h1);
        chk("t4_ready", 64'(a_ready), 64'h0);
        idle();
        chk("t4_busy_after", a_busy, 64'h0);
        chk("t4_ready2",     64'(a_ready), 64'h1);

        // 48-entry instance: out-of-range set, non-busy clear, sticky error
        do_reset();
        cyc(0, 1, 50, 0, 0, 0, 0, 0);
        idle();
        chk("t5_busy",  {16'h0, b_busy}, 64'h0);
        chk("t5_count", 64'(b_count), 64'd0);
        chk("t5_err",   64'(b_err), 64'h1);
        cyc(0, 0, 0, 1, 3, 0, 0, 0);
        idle();
        idle();
        chk("t5_err_sticky", 64'(b_err), 64'h1);
        do_reset();
        idle();
        chk("t5_err_rst", 64'(b_err), 64'h0);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            r   = ($urandom_range(0, 999) == 0);
            sv  = ($urandom_range(0, 9) < 6);
            c0v = ($urandom_range(0, 9) < 3);
            c1v = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 99) == 0);
            cyc(r, sv, $urandom_range(0, 63), c0v, $urandom_range(0, 63),
                c1v, $urandom_range(0, 63), fl);
        end
        idle();
        repeat (3) @(negedge clk);
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
